// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character LCD sequencer: runs the power-up init sequence, then writes
// command/data bytes from a valid/ready port with registered, glitch-free pin timing.
module lcd_hd44780_ctrl #(
    parameter int unsigned POWERUP_CYC    = 750000,
    parameter int unsigned SETUP_CYC      = 4,
    parameter int unsigned EN_PULSE_CYC   = 25,
    parameter int unsigned HOLD_CYC       = 4,
    parameter int unsigned CMD_WAIT_CYC   = 2000,
    parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    input  logic       req_rs_i,
    input  logic [7:0] req_data_i,
    output logic       req_ready_o,
    output logic       init_done_o,
    output logic       busy_o,
    output logic [7:0] lcd_data_o,
    output logic       lcd_rw_o,
    output logic       lcd_rs_o,
    output logic       lcd_en_o,
    output logic       lcd_on_o
);

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_CYC = max_u(max_u(max_u(POWERUP_CYC, SETUP_CYC),
                                                  max_u(EN_PULSE_CYC, HOLD_CYC)),
                                            max_u(CMD_WAIT_CYC, CLEAR_WAIT_CYC));
    localparam int unsigned CNT_W     = $clog2(MAX_CYC + 1);
    localparam int unsigned LAST_STEP = 5;

    localparam logic [CNT_W-1:0] PWR_LD = CNT_W'((POWERUP_CYC >= 2) ? POWERUP_CYC - 2 : 0);
    localparam logic [CNT_W-1:0] SU_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD  = CNT_W'(EN_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LD = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LD = CNT_W'(CLEAR_WAIT_CYC - 1);

    // Byte load is folded into the transitions that enter ST_SETUP, so it costs no cycle.
    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } state_t;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return 8'h38;
            3'd3:             return 8'h0C;
            3'd4:             return 8'h01;
            3'd5:             return 8'h06;
            default:          return 8'h00;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       step_q, step_d;
    logic [7:0]       data_d;
    logic             rs_d, en_d, ready_d, done_d;
    logic             is_slow_c;

    // Clear (0x01) and return-home (0x02/0x03) need the long post-write wait.
    assign is_slow_c = !lcd_rs_o && (lcd_data_o[7:2] == 6'd0) && (lcd_data_o[1:0] != 2'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        data_d  = lcd_data_o;
        rs_d    = lcd_rs_o;
        done_d  = init_done_o;

        case (state_q)
            ST_PWRUP: begin
                // First post-reset cycle is flagged by lcd_on_o still being low.
                if (lcd_on_o ? (cnt_q == '0) : (POWERUP_CYC == 1)) begin
                    state_d = ST_SETUP;
                    cnt_d   = SU_LD;
                    step_d  = 3'd0;
                    data_d  = init_byte(3'd0);
                    rs_d    = 1'b0;
                end else if (!lcd_on_o) begin
                    cnt_d = PWR_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_EN_HI;
                    cnt_d   = EN_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_EN_HI: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HD_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT;
                    cnt_d   = is_slow_c ? CLR_LD : CMD_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (init_done_o || (step_q == 3'(LAST_STEP))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_SETUP;
                    cnt_d   = SU_LD;
                    step_d  = step_q + 3'd1;
                    data_d  = init_byte(step_q + 3'd1);
                    rs_d    = 1'b0;
                end
            end
            ST_IDLE: begin
                if (req_valid_i) begin
                    state_d = ST_SETUP;
                    cnt_d   = SU_LD;
                    data_d  = req_data_i;
                    rs_d    = req_rs_i;
                end
            end
            default: begin
                state_d = ST_PWRUP;
                cnt_d   = '0;
            end
        endcase

        en_d    = (state_d == ST_EN_HI);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_PWRUP;
            cnt_q       <= '0;
            step_q      <= 3'd0;
            lcd_data_o  <= 8'h00;
            lcd_rs_o    <= 1'b0;
            lcd_en_o    <= 1'b0;
            lcd_on_o    <= 1'b0;
            init_done_o <= 1'b0;
            req_ready_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            lcd_data_o  <= data_d;
            lcd_rs_o    <= rs_d;
            lcd_en_o    <= en_d;
            lcd_on_o    <= 1'b1;
            init_done_o <= done_d;
            req_ready_o <= ready_d;
        end
    end

    assign busy_o   = ~req_ready_o;
    assign lcd_rw_o = 1'b0;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Scoreboard bench for lcd_hd44780_ctrl: expected EN pulses are queued as stimulus
// is applied and matched as the controller produces them on the pins.
module tb_lcd_hd44780_ctrl;

    localparam int unsigned P_PWR = 100;
    localparam int unsigned P_SU  = 2;
    localparam int unsigned P_EN  = 4;
    localparam int unsigned P_HD  = 2;
    localparam int unsigned P_CMD = 10;
    localparam int unsigned P_CLR = 30;
    localparam int          T_CMD = int'(P_SU + P_EN + P_HD + P_CMD);
    localparam int          T_CLR = int'(P_SU + P_EN + P_HD + P_CLR);

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, init_done, busy;
    logic [7:0] lcd_data;
    logic       lcd_rw, lcd_rs, lcd_en, lcd_on;

    lcd_hd44780_ctrl #(
        .POWERUP_CYC(P_PWR), .SETUP_CYC(P_SU), .EN_PULSE_CYC(P_EN),
        .HOLD_CYC(P_HD), .CMD_WAIT_CYC(P_CMD), .CLEAR_WAIT_CYC(P_CLR)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_rs_i(req_rs), .req_data_i(req_data),
        .req_ready_o(req_ready), .init_done_o(init_done), .busy_o(busy),
        .lcd_data_o(lcd_data), .lcd_rw_o(lcd_rw), .lcd_rs_o(lcd_rs),
        .lcd_en_o(lcd_en), .lcd_on_o(lcd_on)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: pops the scoreboard on each EN rise, checks width and stability on fall.
    logic       en_q = 1'b0;
    logic       in_rst = 1'b1;
    int         hi_cnt = 0;
    int         prev_rise = 0;
    logic [8:0] cap = 9'd0;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_rst = 1'b1;
            en_q   = 1'b0;
            hi_cnt = 0;
        end else begin
            if (in_rst) begin
                in_rst    = 1'b0;
                prev_rise = cyc - 1;
            end
            if (lcd_en && !en_q) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 32'(sb.size()), 32'd1);
                end else begin
                    mon_e = sb.pop_front();
                    check("pulse_data", 32'(lcd_data), 32'(mon_e.data));
                    check("pulse_rs", 32'(lcd_rs), 32'(mon_e.rs));
                    if (mon_e.gap != 0) check("rise_gap", 32'(cyc - prev_rise), 32'(mon_e.gap));
                end
                prev_rise = cyc;
                hi_cnt    = 1;
                cap       = {lcd_rs, lcd_data};
            end else if (lcd_en) begin
                hi_cnt++;
            end else if (en_q) begin
                check("en_width", 32'(hi_cnt), 32'(P_EN));
                check("pins_stable_en", 32'({lcd_rs, lcd_data}), 32'(cap));
            end
            en_q = lcd_en;
        end
    end

    task automatic push_init();
        logic [7:0] bytes [6];
        bytes = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            e.rs   = 1'b0;
            e.data = bytes[i];
            e.gap  = (i == 0) ? int'(P_PWR + P_SU) : ((i == 5) ? T_CLR : T_CMD);
            sb.push_back(e);
        end
    endtask

    task automatic push_exp(input logic rs, input logic [7:0] d, input int gap);
        exp_t e;
        e.rs   = rs;
        e.data = d;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_data"}, 32'(lcd_data), 32'h00);
        check({tag, "_rs"}, 32'(lcd_rs), 32'd0);
        check({tag, "_en"}, 32'(lcd_en), 32'd0);
        check({tag, "_rw"}, 32'(lcd_rw), 32'd0);
        check({tag, "_on"}, 32'(lcd_on), 32'd0);
        check({tag, "_done"}, 32'(init_done), 32'd0);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!init_done && n < 1000) begin
            @(negedge clk);
            n++;
            if (req_ready && !init_done) check({tag, "_ready_early"}, 32'(req_ready), 32'd0);
        end
        if (!init_done) check({tag, "_timeout"}, 32'(init_done), 32'd1);
        check({tag, "_ready_with_done"}, 32'(req_ready), 32'd1);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
    endtask

    // One write: drive for one cycle, then check pin stability and busy duration.
    task automatic send(input logic rs, input logic [7:0] d, input int exp_busy, input string tag);
        int   acc;
        int   k = 0;
        logic stable = 1'b1;
        wait_ready(tag);
        #1;
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        push_exp(rs, d, 0);
        @(negedge clk);
        acc = cyc;
        req_valid = 1'b0;
        req_rs    = ~rs;
        req_data  = ~d;
        check({tag, "_ready_drop"}, 32'(req_ready), 32'd0);
        while (!req_ready && k < 1000) begin
            if (k < int'(P_SU + P_EN + P_HD) && (lcd_data !== d || lcd_rs !== rs)) stable = 1'b0;
            @(negedge clk);
            k++;
        end
        check({tag, "_pins_stable"}, 32'(stable), 32'd1);
        check({tag, "_busy_cycles"}, 32'(cyc - acc), 32'(exp_busy));
    endtask

    initial begin
        int acc1;
        int acc2;

        // Reset values and full init sequence
        repeat (3) @(negedge clk);
        check_reset_vals("rst1");
        push_init();
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("lcd_on_after_release", 32'(lcd_on), 32'd1);
        wait_done("init1");
        check("init1_all_pulses", 32'(sb.size()), 32'd0);

        // Single writes: data, clear, home, non-slow command, data 0x02
        repeat (3) @(negedge clk);
        send(1'b1, 8'h41, T_CMD, "w41");
        send(1'b0, 8'h01, T_CLR, "clear");
        send(1'b1, 8'h02, T_CMD, "data02");
        send(1'b0, 8'h03, T_CLR, "home03");
        send(1'b0, 8'h0C, T_CMD, "cmd0c");

        // Back-to-back with valid held
        wait_ready("b2b");
        #1;
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h48;
        push_exp(1'b1, 8'h48, 0);
        @(negedge clk);
        acc1 = cyc;
        check("b2b_ready_drop1", 32'(req_ready), 32'd0);
        req_data = 8'h49;
        push_exp(1'b1, 8'h49, T_CMD + 1);
        wait_ready("b2b2");
        @(negedge clk);
        acc2 = cyc;
        req_valid = 1'b0;
        check("b2b_ready_drop2", 32'(req_ready), 32'd0);
        check("b2b_period", 32'(acc2 - acc1), 32'(T_CMD + 1));
        wait_ready("b2b_end");
        check("b2b_all_pulses", 32'(sb.size()), 32'd0);

        // Asynchronous reset in the middle of an EN pulse
        #1;
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h33;
        push_exp(1'b1, 8'h33, 0);
        @(negedge clk);
        req_valid = 1'b0;
        begin
            int n = 0;
            while (!lcd_en && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!lcd_en) check("midrst_en_timeout", 32'(lcd_en), 32'd1);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        repeat (2) @(negedge clk);
        push_init();
        #2 rst_n = 1'b1;
        wait_done("init2");
        check("init2_all_pulses", 32'(sb.size()), 32'd0);

        // Valid held from the start of init is ignored until IDLE
        @(negedge clk);
        #2 rst_n = 1'b0;
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h55;
        repeat (2) @(negedge clk);
        push_init();
        push_exp(1'b1, 8'h55, 0);
        #2 rst_n = 1'b1;
        wait_done("init3");
        @(negedge clk);
        check("init3_accept_on_done", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        wait_ready("init3_end");
        check("init3_all_pulses", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
